// File: rtl/gcd_ctrl.sv
// -----------------------------------------------------------------------------
// gcd_ctrl
//
// Control FSM for a 16-bit subtraction-based GCD datapath. It sequences the
// A/B operand registers and their 2:1 load muxes (0 = external operand,
// 1 = subtractor result), steers the subtractor direction, and stops when the
// operands are equal or when either operand is zero. It provides a start/done
// handshake and an iteration counter.
//
// Optional feature: define GCD_TIMEOUT_EN to enable the iteration watchdog.
// When the run has performed MAX_ITER subtractions, it ends with err=1.
// When the macro is undefined, err is constant 0.
//
// Parameters
//   CNT_W     width of iter_cnt
//   MAX_ITER  watchdog limit (only used with GCD_TIMEOUT_EN; must fit CNT_W)
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             run request, sampled only in IDLE
//   a_lt_b, a_eq_b    datapath compare flags (only looked at in CMP)
//   a_zero, b_zero    datapath zero flags    (only looked at in CMP)
//   ld_a, ld_b        operand register load enables
//   sel_a, sel_b      operand mux selects: 0 external, 1 subtractor result
//   sel_sub           subtractor direction: 0 A-B, 1 B-A
//   res_sel           result pick: 0 A, 1 B (registered, valid with done)
//   busy              high in LOAD/CMP/SUB_A/SUB_B
//   done              one-cycle completion pulse
//   err               watchdog tripped (registered, valid with done)
//   iter_cnt          subtractions in the current run, saturating
// -----------------------------------------------------------------------------
module gcd_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  input  logic             a_zero,
  input  logic             b_zero,
  output logic             ld_a,
  output logic             ld_b,
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_sub,
  output logic             res_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CMP,
    SUB_A,
    SUB_B,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

`ifdef GCD_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  // With the watchdog disabled, the limit compare folds away.
  // err_nxt is then never set, so err stays at its reset value of 0.
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic             res_sel_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] iter_nxt;
  logic             limit_hit;

  assign limit_hit = TIMEOUT_EN && (iter_cnt == ITER_LIMIT);

  // NOTE: state is updated with non-blocking assignments only. Every
  // register then samples the values from before this clock edge, which
  // avoids simulation races between processes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      res_sel  <= 1'b0;
      err      <= 1'b0;
      iter_cnt <= '0;
    end else begin
      state    <= state_nxt;
      res_sel  <= res_sel_nxt;
      err      <= err_nxt;
      iter_cnt <= iter_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case
  // statement. A path that does not assign a signal then cannot infer a latch.
  always_comb begin
    state_nxt   = state;
    res_sel_nxt = res_sel;
    err_nxt     = err;
    iter_nxt    = iter_cnt;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    sel_a       = 1'b0;
    sel_b       = 1'b0;
    sel_sub     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end

      LOAD: begin
        busy        = 1'b1;
        ld_a        = 1'b1;
        ld_b        = 1'b1;
        iter_nxt    = '0;
        err_nxt     = 1'b0;
        res_sel_nxt = 1'b0;
        state_nxt   = CMP;
      end

      CMP: begin
        busy = 1'b1;
        // Zero checks come first, so gcd(x,0) and gcd(0,0) never subtract.
        // If both operands are zero, the b_zero branch returns A, which is 0.
        if (b_zero) begin
          res_sel_nxt = 1'b0;
          state_nxt   = DONE;
        end else if (a_zero) begin
          res_sel_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (a_eq_b) begin
          res_sel_nxt = 1'b0;
          state_nxt   = DONE;
        end else if (limit_hit) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (a_lt_b) begin
          state_nxt = SUB_B;
        end else begin
          state_nxt = SUB_A;
        end
      end

      SUB_A: begin
        busy      = 1'b1;
        ld_a      = 1'b1;
        sel_a     = 1'b1;
        sel_sub   = 1'b0;
        if (iter_cnt != '1) iter_nxt = iter_cnt + CNT_W'(1);
        state_nxt = CMP;
      end

      SUB_B: begin
        busy      = 1'b1;
        ld_b      = 1'b1;
        sel_b     = 1'b1;
        sel_sub   = 1'b1;
        if (iter_cnt != '1) iter_nxt = iter_cnt + CNT_W'(1);
        state_nxt = CMP;
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
